ctrl_fsm: RTL and testbench

Multi-cycle control unit of the 16-bit CPU. It sequences every instruction through fetch, decode, execute and optional memory phases. It drives the program-counter select code, the instruction-register load, register-file write and the shared memory request handshake. A watchdog halts the core on a memory access that is never acknowledged, and a counter tracks retired instructions.

---
 rtl/mycpu_pkg.sv | 40 ++++
 rtl/ctrl_fsm_svamod.sv | 52 +++++
 rtl/mem_watchdog.sv | 39 +++
 rtl/ctrl_fsm.sv | 204 ++++++++++++++++++++
 tb/tb_ctrl_fsm.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/mycpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mycpu_pkg
//  Description : Shared types and constants for the 16-bit CPU control path:
//                controller state encoding, opcode values and PC-select codes.
//  Revision    : 1.0 - initial release
// ============================================================================
package mycpu_pkg;

    // Controller states, explicitly encoded
    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_HALT   = 3'd4
    } ctrl_state_t;

    // Opcodes live in ins[15:12]; 0001..0111 are ALU operations
    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LD   = 4'h8;
    localparam logic [3:0] OP_ST   = 4'h9;
    localparam logic [3:0] OP_BZ   = 4'hA;
    localparam logic [3:0] OP_BNZ  = 4'hB;
    localparam logic [3:0] OP_JMP  = 4'hC;
    localparam logic [3:0] OP_HALT = 4'hF;

    // PC select codes, shared with the PC block
    localparam logic [1:0] PS_HOLD = 2'b00;
    localparam logic [1:0] PS_INC  = 2'b01;
    localparam logic [1:0] PS_BRA  = 2'b10;
    localparam logic [1:0] PS_JMP  = 2'b11;

    // True for the register-to-register ALU opcode group
    function automatic logic is_alu_op(input logic [3:0] op);
        return (op >= 4'h1) && (op <= 4'h7);
    endfunction

endpackage : mycpu_pkg
`default_nettype wire

// File: rtl/ctrl_fsm_svamod.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_fsm_svamod
//  Description : Companion assertions for ctrl_fsm: unknown-value checks,
//                quiet outputs during reset, PC-select / IR-load exclusivity
//                and memory request held until acknowledged.
//  Revision    : 1.0 - initial release
// ============================================================================
module ctrl_fsm_svamod (
    input logic        clk,
    input logic        rst,
    input logic [15:0] i_ins,
    input logic        i_ack,
    input logic [1:0]  i_ps,
    input logic        i_ir_load,
    input logic        i_rf_we,
    input logic        i_wb_sel,
    input logic [2:0]  i_alu_op,
    input logic        i_mem_req,
    input logic        i_mem_we,
    input logic        i_addr_sel,
    input logic        i_halted,
    input logic        i_bus_err,
    input logic        i_illegal
);

    logic [13:0] w_ctrl;
    assign w_ctrl = {i_ps, i_ir_load, i_rf_we, i_wb_sel, i_alu_op,
                     i_mem_req, i_mem_we, i_addr_sel, i_halted, i_illegal, i_bus_err};

    // Control outputs never carry X/Z out of reset
    a_ctrl_known: assert property (@(posedge clk) disable iff (rst)
        !$isunknown(w_ctrl));

    // A PC update only happens with a valid instruction in the IR
    a_ins_known: assert property (@(posedge clk) disable iff (rst)
        (i_ps != 2'b00) |-> !$isunknown(i_ins));

    // Everything except the sticky error is silent while reset is held
    a_rst_quiet: assert property (@(posedge clk)
        rst |-> (w_ctrl[13:1] == 13'd0 && !i_bus_err));

    // The IR is never loaded in the same cycle as a PC update
    a_ps_irl_excl: assert property (@(posedge clk) disable iff (rst)
        !(i_ir_load && (i_ps != 2'b00)));

    // A pending request stays up until ack, unless the watchdog fires
    a_req_held: assert property (@(posedge clk) disable iff (rst)
        (i_mem_req && !i_ack) |=> (i_mem_req || i_bus_err));

endmodule : ctrl_fsm_svamod
`default_nettype wire

// File: rtl/mem_watchdog.sv
`default_nettype none
// ============================================================================
//  Module      : mem_watchdog
//  Description : Wait-cycle counter for the shared memory request. Flags the
//                cycle in which one more unacknowledged wait would reach
//                MEM_TIMEOUT, so an ack in that same cycle still wins.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_watchdog #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_req,
    input  logic i_ack,
    output logic o_at_limit
);

    // Count value held during the last permitted wait cycle
    localparam logic [7:0] c_LAST_WAIT = 8'(MEM_TIMEOUT - 1);

    logic [7:0] r_count;

    // Wait counter: cleared on every state change, counts unacknowledged requests
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= 8'd0;
        end else if (i_clr) begin
            r_count <= 8'd0;
        end else if (i_req && !i_ack) begin
            r_count <= r_count + 8'd1;
        end
    end

    assign o_at_limit = (r_count == c_LAST_WAIT);

endmodule : mem_watchdog
`default_nettype wire

// File: rtl/ctrl_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_fsm
//  Description : Multi-cycle control unit of the 16-bit CPU. Sequences each
//                instruction through FETCH, DECODE, EXEC and optional MEM,
//                drives PC select, IR load, register write and the memory
//                handshake, halts on HALT or memory timeout and counts
//                retired instructions.
//  Revision    : 1.0 - initial release
// ============================================================================
module ctrl_fsm
    import mycpu_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ins_in,
    input  logic        zero_in,
    input  logic        mem_ack_in,
    output logic [1:0]  ps_out,
    output logic        ir_load_out,
    output logic        rf_we_out,
    output logic        wb_sel_out,
    output logic [2:0]  alu_op_out,
    output logic        mem_req_out,
    output logic        mem_we_out,
    output logic        addr_sel_out,
    output logic        halted_out,
    output logic        bus_err_out,
    output logic        illegal_out,
    output logic [15:0] retired_out
);

    ctrl_state_t r_state;
    ctrl_state_t w_state_nxt;

    logic [3:0]  w_op;
    logic [1:0]  w_ps;
    logic        w_ir_load;
    logic        w_rf_we;
    logic        w_wb_sel;
    logic        w_mem_req;
    logic        w_mem_we;
    logic        w_addr_sel;
    logic        w_halted;
    logic        w_illegal;
    logic        w_timeout;
    logic        w_at_limit;
    logic        w_wd_clr;
    logic        r_bus_err;
    logic [15:0] r_retired;

    assign w_op = ins_in[15:12];

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and control decode from state, opcode, zero flag and ack
    always_comb begin
        w_state_nxt = r_state;
        w_ps        = PS_HOLD;
        w_ir_load   = 1'b0;
        w_rf_we     = 1'b0;
        w_wb_sel    = 1'b0;
        w_mem_req   = 1'b0;
        w_mem_we    = 1'b0;
        w_addr_sel  = 1'b0;
        w_halted    = 1'b0;
        w_illegal   = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            ST_FETCH: begin
                w_mem_req = 1'b1;
                if (mem_ack_in) begin
                    w_ir_load   = 1'b1;
                    w_state_nxt = ST_DECODE;
                end else if (w_at_limit) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = ST_HALT;
                end
            end
            ST_DECODE: begin
                w_state_nxt = ST_EXEC;
            end
            ST_EXEC: begin
                w_state_nxt = ST_FETCH;
                if (w_op == OP_NOP) begin
                    w_ps = PS_INC;
                end else if (is_alu_op(w_op)) begin
                    w_rf_we = 1'b1;
                    w_ps    = PS_INC;
                end else if (w_op == OP_BZ) begin
                    w_ps = zero_in ? PS_BRA : PS_INC;
                end else if (w_op == OP_BNZ) begin
                    w_ps = zero_in ? PS_INC : PS_BRA;
                end else if (w_op == OP_JMP) begin
                    w_ps = PS_JMP;
                end else if (w_op == OP_LD || w_op == OP_ST) begin
                    w_state_nxt = ST_MEM;
                end else if (w_op == OP_HALT) begin
                    w_state_nxt = ST_HALT;
                end else begin
                    w_illegal = 1'b1;
                    w_ps      = PS_INC;
                end
            end
            ST_MEM: begin
                w_mem_req  = 1'b1;
                w_addr_sel = 1'b1;
                w_mem_we   = (w_op == OP_ST);
                if (mem_ack_in) begin
                    if (w_op == OP_LD) begin
                        w_rf_we  = 1'b1;
                        w_wb_sel = 1'b1;
                    end
                    w_ps        = PS_INC;
                    w_state_nxt = ST_FETCH;
                end else if (w_at_limit) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = ST_HALT;
                end
            end
            ST_HALT: begin
                w_halted = 1'b1;
            end
            default: begin
                w_state_nxt = ST_FETCH;
            end
        endcase
    end

    // Any state change restarts the wait count, covering entry to FETCH and MEM
    assign w_wd_clr = (w_state_nxt != r_state);

    mem_watchdog #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_mem_watchdog (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (w_wd_clr),
        .i_req      (w_mem_req),
        .i_ack      (mem_ack_in),
        .o_at_limit (w_at_limit)
    );

    // Sticky bus-error flag, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bus_err <= 1'b0;
        end else if (w_timeout) begin
            r_bus_err <= 1'b1;
        end
    end

    // Retired-instruction counter: one count per PC update, wraps naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_retired <= 16'd0;
        end else if (ps_out != PS_HOLD) begin
            r_retired <= r_retired + 16'd1;
        end
    end

    // Reset silences every control output immediately, even mid-instruction
    assign ps_out       = rst ? PS_HOLD : w_ps;
    assign ir_load_out  = !rst && w_ir_load;
    assign rf_we_out    = !rst && w_rf_we;
    assign wb_sel_out   = !rst && w_wb_sel;
    assign alu_op_out   = rst ? 3'd0 : ins_in[14:12];
    assign mem_req_out  = !rst && w_mem_req;
    assign mem_we_out   = !rst && w_mem_we;
    assign addr_sel_out = !rst && w_addr_sel;
    assign halted_out   = !rst && w_halted;
    assign illegal_out  = !rst && w_illegal;
    assign bus_err_out  = r_bus_err;
    assign retired_out  = r_retired;

    ctrl_fsm_svamod u_ctrl_fsm_svamod (
        .clk        (clk),
        .rst        (rst),
        .i_ins      (ins_in),
        .i_ack      (mem_ack_in),
        .i_ps       (ps_out),
        .i_ir_load  (ir_load_out),
        .i_rf_we    (rf_we_out),
        .i_wb_sel   (wb_sel_out),
        .i_alu_op   (alu_op_out),
        .i_mem_req  (mem_req_out),
        .i_mem_we   (mem_we_out),
        .i_addr_sel (addr_sel_out),
        .i_halted   (halted_out),
        .i_bus_err  (bus_err_out),
        .i_illegal  (illegal_out)
    );

endmodule : ctrl_fsm
`default_nettype wire

// File: tb/tb_ctrl_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ctrl_fsm
//  Description : Directed self-checking bench for ctrl_fsm with a short
//                memory timeout so watchdog boundaries are reachable.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ctrl_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] ins_in;
    logic        zero_in;
    logic        mem_ack_in;
    logic [1:0]  ps_out;
    logic        ir_load_out;
    logic        rf_we_out;
    logic        wb_sel_out;
    logic [2:0]  alu_op_out;
    logic        mem_req_out;
    logic        mem_we_out;
    logic        addr_sel_out;
    logic        halted_out;
    logic        bus_err_out;
    logic        illegal_out;
    logic [15:0] retired_out;

    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] exp_ret;

    ctrl_fsm #(.MEM_TIMEOUT(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .ins_in       (ins_in),
        .zero_in      (zero_in),
        .mem_ack_in   (mem_ack_in),
        .ps_out       (ps_out),
        .ir_load_out  (ir_load_out),
        .rf_we_out    (rf_we_out),
        .wb_sel_out   (wb_sel_out),
        .alu_op_out   (alu_op_out),
        .mem_req_out  (mem_req_out),
        .mem_we_out   (mem_we_out),
        .addr_sel_out (addr_sel_out),
        .halted_out   (halted_out),
        .bus_err_out  (bus_err_out),
        .illegal_out  (illegal_out),
        .retired_out  (retired_out)
    );

    always #5 clk = ~clk;

    // Single comparison point for every check
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Compare the whole control bundle
    // order: ps, ir_load, rf_we, wb_sel, mem_req, mem_we, addr_sel, halted, bus_err, illegal
    task automatic chk_ctl(input string tag, input logic [1:0] ps, input logic irl,
                           input logic we, input logic wb, input logic req, input logic mwe,
                           input logic asel, input logic hlt, input logic berr, input logic ill);
        chk(tag,
            {21'd0, ps_out, ir_load_out, rf_we_out, wb_sel_out, mem_req_out,
             mem_we_out, addr_sel_out, halted_out, bus_err_out, illegal_out},
            {21'd0, ps, irl, we, wb, req, mwe, asel, hlt, berr, ill});
    endtask

    task automatic drive(input logic [15:0] ins, input logic ack, input logic zero);
        ins_in     = ins;
        mem_ack_in = ack;
        zero_in    = zero;
        #1;
    endtask

    task automatic adv();
        @(negedge clk);
    endtask

    // Zero-wait FETCH/DECODE/EXEC instruction; ends in the following FETCH
    task automatic run_simple(input string tag, input logic [15:0] ins, input logic zero,
                              input logic [1:0] eps, input logic ewe, input logic eill);
        drive(ins, 1'b1, zero);
        chk_ctl({tag, "_fetch"}, 2'b00, 1, 0, 0, 1, 0, 0, 0, 0, 0);
        adv(); drive(ins, 1'b0, zero);
        adv(); drive(ins, 1'b0, zero);
        chk_ctl({tag, "_exec"}, eps, 0, ewe, 0, 0, 0, 0, 0, 0, eill);
        adv();
        if (eps != 2'b00) exp_ret = exp_ret + 16'd1;
        drive(16'h0000, 1'b0, 1'b0);
        chk({tag, "_retired"}, {16'd0, retired_out}, {16'd0, exp_ret});
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got stuck, expected completion");
        $fatal(1, "simulation time limit");
    end

    initial begin
        rst = 1'b1; ins_in = 16'h0; zero_in = 1'b0; mem_ack_in = 1'b0;
        exp_ret = 16'd0;
        repeat (2) adv();

        // Reset: outputs silent even with ack driven
        drive(16'h1000, 1'b1, 1'b1);
        chk_ctl("rst_ctl", 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_retired", {16'd0, retired_out}, 32'd0);
        chk("rst_alu_op", {29'd0, alu_op_out}, 32'd0);
        rst = 1'b0;

        // ALU 0x1000 with zero-wait fetch
        drive(16'h1000, 1'b1, 1'b0);
        chk_ctl("alu_fetch", 2'b00, 1, 0, 0, 1, 0, 0, 0, 0, 0);
        adv(); drive(16'h1000, 1'b0, 1'b0);
        chk_ctl("alu_decode", 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        adv(); drive(16'h1000, 1'b0, 1'b0);
        chk_ctl("alu_exec", 2'b01, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        chk("alu_op", {29'd0, alu_op_out}, 32'd1);
        adv(); exp_ret = 16'd1;

        // LD 0x8000, two wait cycles in FETCH and in MEM
        drive(16'h8000, 1'b0, 1'b0);
        chk("alu_retired", {16'd0, retired_out}, 32'd1);
        chk_ctl("ld_f0", 2'b00, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        adv(); drive(16'h8000, 1'b0, 1'b0);
        chk_ctl("ld_f1", 2'b00, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        adv(); drive(16'h8000, 1'b1, 1'b0);
        chk_ctl("ld_f2", 2'b00, 1, 0, 0, 1, 0, 0, 0, 0, 0);
        adv(); drive(16'h8000, 1'b0, 1'b0);
        chk_ctl("ld_decode", 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        adv(); drive(16'h8000, 1'b0, 1'b0);
        chk_ctl("ld_exec", 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        adv(); drive(16'h8000, 1'b0, 1'b0);
        chk_ctl("ld_m0", 2'b00, 0, 0, 0, 1, 0, 1, 0, 0, 0);
        adv(); drive(16'h8000, 1'b0, 1'b0);
        chk_ctl("ld_m1", 2'b00, 0, 0, 0, 1, 0, 1, 0, 0, 0);
        adv(); drive(16'h8000, 1'b1, 1'b0);
        chk_ctl("ld_m2", 2'b01, 0, 1, 1, 1, 0, 1, 0, 0, 0);
        adv(); exp_ret = 16'd2;

        // ST 0x9000 zero-wait
        drive(16'h9000, 1'b1, 1'b0);
        chk("ld_retired", {16'd0, retired_out}, 32'd2);
        chk_ctl("st_fetch", 2'b00, 1, 0, 0, 1, 0, 0, 0, 0, 0);
        adv(); drive(16'h9000, 1'b0, 1'b0);
        adv(); drive(16'h9000, 1'b0, 1'b0);
        chk_ctl("st_exec", 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        adv(); drive(16'h9000, 1'b1, 1'b0);
        chk_ctl("st_mem", 2'b01, 0, 0, 0, 1, 1, 1, 0, 0, 0);
        adv(); exp_ret = 16'd3;

        // Branches, jump, ALU group top, illegal opcodes
        run_simple("nop",   16'h0000, 1'b0, 2'b01, 1'b0, 1'b0);
        run_simple("bz_t",  16'hA1C5, 1'b1, 2'b10, 1'b0, 1'b0);
        run_simple("bz_f",  16'hA1C5, 1'b0, 2'b01, 1'b0, 1'b0);
        run_simple("bnz_t", 16'hB000, 1'b0, 2'b10, 1'b0, 1'b0);
        run_simple("bnz_f", 16'hB000, 1'b1, 2'b01, 1'b0, 1'b0);
        run_simple("jmp",   16'hC000, 1'b0, 2'b11, 1'b0, 1'b0);
        run_simple("alu7",  16'h7123, 1'b1, 2'b01, 1'b1, 1'b0);
        run_simple("ill_d", 16'hD000, 1'b0, 2'b01, 1'b0, 1'b1);
        run_simple("ill_e", 16'hE000, 1'b0, 2'b01, 1'b0, 1'b1);

        // Counter wrap: preset near the top, then retire two NOPs
        force dut.r_retired = 16'hFFFE;
        #1;
        release dut.r_retired;
        exp_ret = 16'hFFFE;
        run_simple("wrap1", 16'h0000, 1'b0, 2'b01, 1'b0, 1'b0);
        run_simple("wrap2", 16'h0000, 1'b0, 2'b01, 1'b0, 1'b0);

        // HALT: held, acks ignored, no retire
        drive(16'hF000, 1'b1, 1'b0);
        adv(); drive(16'hF000, 1'b0, 1'b0);
        adv(); drive(16'hF000, 1'b0, 1'b0);
        chk_ctl("halt_exec", 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            adv(); drive(16'hF000, i[0], 1'b1);
            chk_ctl("halt_hold", 2'b00, 0, 0, 0, 0, 0, 0, 1, 0, 0);
            chk("halt_retired", {16'd0, retired_out}, {16'd0, exp_ret});
        end
        rst = 1'b1; #1;
        chk_ctl("halt_rst", 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        adv(); rst = 1'b0; exp_ret = 16'd0;

        // Watchdog: four unacknowledged fetch cycles, then halt with bus error
        for (int i = 0; i < 4; i++) begin
            drive(16'h0000, 1'b0, 1'b0);
            chk_ctl("to_wait", 2'b00, 0, 0, 0, 1, 0, 0, 0, 0, 0);
            adv();
        end
        drive(16'h0000, 1'b1, 1'b0);
        chk_ctl("to_halt", 2'b00, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        chk("to_retired", {16'd0, retired_out}, 32'd0);
        adv(); drive(16'h0000, 1'b0, 1'b0);
        chk_ctl("to_sticky", 2'b00, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        rst = 1'b1; #1;
        chk("to_rst_berr", {31'd0, bus_err_out}, 32'd0);
        adv(); rst = 1'b0;

        // Ack in the last permitted wait cycle completes without error
        for (int i = 0; i < 3; i++) begin
            drive(16'h0000, 1'b0, 1'b0);
            adv();
        end
        drive(16'h0000, 1'b1, 1'b0);
        chk_ctl("ackwin_fetch", 2'b00, 1, 0, 0, 1, 0, 0, 0, 0, 0);
        adv(); drive(16'h0000, 1'b0, 1'b0);
        chk_ctl("ackwin_decode", 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        adv(); drive(16'h0000, 1'b0, 1'b0);
        chk_ctl("ackwin_exec", 2'b01, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        adv(); drive(16'h0000, 1'b0, 1'b0);
        chk("ackwin_retired", {16'd0, retired_out}, 32'd1);

        // Reset asserted during MEM with ack present: nothing commits
        drive(16'h8000, 1'b1, 1'b0);
        adv(); drive(16'h8000, 1'b0, 1'b0);
        adv(); drive(16'h8000, 1'b0, 1'b0);
        adv(); drive(16'h8000, 1'b0, 1'b0);
        chk_ctl("rmem_m0", 2'b00, 0, 0, 0, 1, 0, 1, 0, 0, 0);
        rst = 1'b1; mem_ack_in = 1'b1; #1;
        chk_ctl("rmem_rst", 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        adv(); rst = 1'b0;
        drive(16'h8000, 1'b0, 1'b0);
        chk_ctl("rmem_fetch", 2'b00, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        chk("rmem_retired", {16'd0, retired_out}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_ctrl_fsm
`default_nettype wire
